// File: rtl/rr_pop_arbiter.sv
// -----------------------------------------------------------------------------
// rr_pop_arbiter
//   Round-robin pop arbiter for a bank of NUM_FIFOS FIFOs. A channel requests
//   when it is non-empty and unmasked. The one-hot gnt vector is the FIFO pop
//   bus and the output mux select in the same cycle (zero grant-to-pop latency).
//   An owner may keep the grant for up to MAX_BURST back-to-back pops. After
//   that, or as soon as the owner stops requesting, priority rotates to the
//   channel after it.
//
// Ports
//   clk        clock, all state on posedge
//   rst        asynchronous active-low reset
//   en         global arbitration enable (low = stall, state held)
//   out_ready  consumer can take data this cycle (low = stall)
//   empty      FIFO empty flags, one per channel
//   mask       1 = channel eligible
//   gnt        one-hot pop/select, combinational from state and inputs
//   gnt_tag    index of the granted channel, valid when gnt != 0
//   busy       high while a multi-pop burst is in progress
// -----------------------------------------------------------------------------
module rr_pop_arbiter #(
  parameter int NUM_FIFOS = 4,
  parameter int MAX_BURST = 1,
  parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
  parameter int CNTWIDTH  = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 out_ready,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [NUM_FIFOS-1:0] mask,
  output logic [NUM_FIFOS-1:0] gnt,
  output logic [TAGWIDTH-1:0]  gnt_tag,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [TAGWIDTH-1:0]   ptr_q, ptr_d;
  logic [TAGWIDTH-1:0]   owner_q, owner_d;
  logic [CNTWIDTH-1:0]   cnt_q, cnt_d;

  logic [NUM_FIFOS-1:0]  req_vec;
  logic                  rr_found;
  logic [TAGWIDTH-1:0]   rr_sel;
  logic [TAGWIDTH-1:0]   rr_idx;
  logic [NUM_FIFOS-1:0]  gnt_raw;
  logic [TAGWIDTH-1:0]   tag_raw;

  // Explicit wrap at NUM_FIFOS-1 so a non-power-of-2 bank never sees an
  // out-of-range index.
  function automatic logic [TAGWIDTH-1:0] wrap_inc(input logic [TAGWIDTH-1:0] v);
    return (v == TAGWIDTH'(NUM_FIFOS - 1)) ? '0 : v + 1'b1;
  endfunction

  assign req_vec = ~empty & mask;

  // First requester at or after ptr, walking the ring once.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = ptr_q;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (!rr_found && req_vec[rr_idx]) begin
        rr_found = 1'b1;
        rr_sel   = rr_idx;
      end
      rr_idx = wrap_inc(rr_idx);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_raw = '0;
    tag_raw = '0;
    unique case (state_q)
      IDLE: begin
        if (en && out_ready && rr_found) begin
          gnt_raw[rr_sel] = 1'b1;
          tag_raw         = rr_sel;
          if (MAX_BURST == 1) begin
            ptr_d = wrap_inc(rr_sel);
          end else begin
            owner_d = rr_sel;
            cnt_d   = CNTWIDTH'(1);
            state_d = BURST;
          end
        end
      end
      BURST: begin
        if (en) begin
          if (!req_vec[owner_q]) begin
            // Owner drained or masked: one bubble, then re-arbitrate.
            ptr_d   = wrap_inc(owner_q);
            state_d = IDLE;
          end else if (out_ready) begin
            gnt_raw[owner_q] = 1'b1;
            tag_raw          = owner_q;
            cnt_d            = cnt_q + 1'b1;
            if (cnt_d == CNTWIDTH'(MAX_BURST)) begin
              ptr_d   = wrap_inc(owner_q);
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low for the whole time reset is held, independent of
  // the request inputs.
  assign gnt     = rst ? gnt_raw : '0;
  assign gnt_tag = rst ? tag_raw : '0;
  assign busy    = rst & (state_q == BURST);

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_pop_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_pop_arbiter
//   Three arbiter instances share the stimulus: 4 channels with single pops,
//   4 channels with bursts of 4, and 3 channels with single pops. A simple
//   occupancy-count FIFO model pops on the selected instance's grant; empty
//   flags update the cycle after a pop.
// -----------------------------------------------------------------------------
module tb_rr_pop_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       out_ready;
  logic [3:0] mask;
  logic [3:0] empty;
  int         fifo_cnt[4];

  logic [3:0] gnt_a, gnt_b;
  logic [2:0] gnt_c;
  logic [1:0] tag_a, tag_b, tag_c;
  logic       busy_a, busy_b, busy_c;

  int dut_sel;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       en;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] tag;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) empty[i] = (fifo_cnt[i] == 0);
  end

  rr_pop_arbiter #(.NUM_FIFOS(4), .MAX_BURST(1)) u_b1 (
    .clk(clk), .rst(rst), .en(en), .out_ready(out_ready),
    .empty(empty), .mask(mask), .gnt(gnt_a), .gnt_tag(tag_a), .busy(busy_a)
  );

  rr_pop_arbiter #(.NUM_FIFOS(4), .MAX_BURST(4)) u_b4 (
    .clk(clk), .rst(rst), .en(en), .out_ready(out_ready),
    .empty(empty), .mask(mask), .gnt(gnt_b), .gnt_tag(tag_b), .busy(busy_b)
  );

  rr_pop_arbiter #(.NUM_FIFOS(3), .MAX_BURST(1)) u_n3 (
    .clk(clk), .rst(rst), .en(en), .out_ready(out_ready),
    .empty(empty[2:0]), .mask(mask[2:0]), .gnt(gnt_c), .gnt_tag(tag_c), .busy(busy_c)
  );

  function automatic logic [3:0] cur_gnt();
    case (dut_sel)
      0:       return gnt_a;
      1:       return gnt_b;
      default: return {1'b0, gnt_c};
    endcase
  endfunction

  function automatic logic [1:0] cur_tag();
    case (dut_sel)
      0:       return tag_a;
      1:       return tag_b;
      default: return tag_c;
    endcase
  endfunction

  function automatic logic cur_busy();
    case (dut_sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with inputs settled: pop on the granted channel at the
  // next posedge, then return at the following negedge.
  task automatic advance();
    logic [3:0] g;
    g = cur_gnt();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (g[i]) fifo_cnt[i]--;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3);
    fifo_cnt[0] = c0;
    fifo_cnt[1] = c1;
    fifo_cnt[2] = c2;
    fifo_cnt[3] = c3;
  endtask

  task automatic add(input string name, input logic e, input logic r,
                     input logic [3:0] g, input logic [1:0] t, input logic b);
    vec_t v;
    v.name = name;
    v.en   = e;
    v.rdy  = r;
    v.gnt  = g;
    v.tag  = t;
    v.busy = b;
    vq.push_back(v);
  endtask

  task automatic add_n(input string name, input int n, input logic [3:0] g,
                       input logic [1:0] t, input logic b);
    for (int k = 0; k < n; k++) add(name, 1'b1, 1'b1, g, t, b);
  endtask

  task automatic run_vecs();
    for (int k = 0; k < vq.size(); k++) begin
      en        = vq[k].en;
      out_ready = vq[k].rdy;
      #1;
      check($sformatf("%s[%0d]_gnt", vq[k].name, k), 32'(cur_gnt()), 32'(vq[k].gnt));
      if (vq[k].gnt != 4'b0000)
        check($sformatf("%s[%0d]_tag", vq[k].name, k), 32'(cur_tag()), 32'(vq[k].tag));
      check($sformatf("%s[%0d]_busy", vq[k].name, k), 32'(cur_busy()), 32'(vq[k].busy));
      if (dut_sel == 2)
        check($sformatf("%s[%0d]_ptr_range", vq[k].name, k), 32'(u_n3.ptr_q < 2'd3), 32'd1);
      advance();
    end
    vq.delete();
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    mask      = 4'b1111;
    dut_sel   = 0;
    load(0, 0, 0, 0);

    // Reset state
    @(negedge clk);
    check("rst_gnt_a", 32'(gnt_a), 32'd0);
    check("rst_gnt_b", 32'(gnt_b), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    check("rst_tag_b", 32'(tag_b), 32'd0);
    rst = 1'b1;

    // T1: single pops rotate over all four channels
    do_reset();
    dut_sel = 0;
    load(3, 3, 3, 3);
    for (int r = 0; r < 3; r++) begin
      add("t1", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
      add("t1", 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0);
      add("t1", 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
      add("t1", 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0);
    end
    add_n("t1_done", 2, 4'b0000, 2'd0, 1'b0);
    run_vecs();

    // T2: bursts of 4 alternating between channels 0 and 2, then drain bubbles
    do_reset();
    dut_sel = 1;
    load(6, 0, 6, 0);
    add_n("t2", 1, 4'b0001, 2'd0, 1'b0);
    add_n("t2", 3, 4'b0001, 2'd0, 1'b1);
    add_n("t2", 1, 4'b0100, 2'd2, 1'b0);
    add_n("t2", 3, 4'b0100, 2'd2, 1'b1);
    add_n("t2", 1, 4'b0001, 2'd0, 1'b0);
    add_n("t2", 1, 4'b0001, 2'd0, 1'b1);
    add_n("t2_bubble", 1, 4'b0000, 2'd0, 1'b1);
    add_n("t2", 1, 4'b0100, 2'd2, 1'b0);
    add_n("t2", 1, 4'b0100, 2'd2, 1'b1);
    add_n("t2_bubble", 1, 4'b0000, 2'd0, 1'b1);
    add_n("t2_done", 1, 4'b0000, 2'd0, 1'b0);
    run_vecs();

    // T3: short owner drains early, then full burst on channel 3
    do_reset();
    dut_sel = 1;
    load(0, 2, 0, 4);
    add_n("t3", 1, 4'b0010, 2'd1, 1'b0);
    add_n("t3", 1, 4'b0010, 2'd1, 1'b1);
    add_n("t3_bubble", 1, 4'b0000, 2'd0, 1'b1);
    add_n("t3", 1, 4'b1000, 2'd3, 1'b0);
    add_n("t3", 3, 4'b1000, 2'd3, 1'b1);
    add_n("t3_done", 1, 4'b0000, 2'd0, 1'b0);
    run_vecs();

    // T4: out_ready stall mid-burst holds the count; burst finishes with 2
    // more pops, then a fresh arbitration follows with no bubble.
    do_reset();
    dut_sel = 1;
    load(6, 0, 0, 0);
    add("t4", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    add("t4", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    for (int k = 0; k < 3; k++) add("t4_stall", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1);
    add("t4", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    add("t4", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    add("t4_rearb", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
    add("t4", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    add("t4_bubble", 1'b1, 1'b1, 4'b0000, 2'd0, 1'b1);
    add("t4_done", 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0);
    run_vecs();

    // T5: asynchronous reset in the middle of a burst on channel 2
    do_reset();
    dut_sel   = 1;
    load(0, 0, 10, 0);
    en        = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t5_pre_gnt0", 32'(gnt_b), 32'b0100);
    check("t5_pre_busy0", 32'(busy_b), 32'd0);
    advance();
    #1;
    check("t5_pre_gnt1", 32'(gnt_b), 32'b0100);
    check("t5_pre_busy1", 32'(busy_b), 32'd1);
    advance();
    rst = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(gnt_b), 32'd0);
    check("t5_rst_tag", 32'(tag_b), 32'd0);
    check("t5_rst_busy", 32'(busy_b), 32'd0);
    advance();
    load(3, 3, 3, 3);
    #1;
    check("t5_hold_gnt", 32'(gnt_b), 32'd0);
    rst = 1'b1;
    #1;
    check("t5_post_gnt", 32'(gnt_b), 32'b0001);
    check("t5_post_tag", 32'(tag_b), 32'd0);
    check("t5_post_busy", 32'(busy_b), 32'd0);
    advance();
    #1;
    check("t5_post_gnt1", 32'(gnt_b), 32'b0001);
    check("t5_post_busy1", 32'(busy_b), 32'd1);
    advance();

    // T6: three channels, middle one masked; pointer wraps 2 -> 0
    do_reset();
    dut_sel = 2;
    mask    = 4'b0101;
    load(2, 2, 2, 0);
    add_n("t6", 1, 4'b0001, 2'd0, 1'b0);
    add_n("t6", 1, 4'b0100, 2'd2, 1'b0);
    add_n("t6", 1, 4'b0001, 2'd0, 1'b0);
    add_n("t6", 1, 4'b0100, 2'd2, 1'b0);
    add_n("t6_done", 2, 4'b0000, 2'd0, 1'b0);
    run_vecs();
    check("t6_masked_untouched", 32'(fifo_cnt[1]), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
